// File: rtl/addition_normalize_round.sv
// Normalize and round stage of a floating-point adder: takes the raw aligned sum,
// normalizes it one bit per cycle, applies round-to-nearest-even and packs the result.
module addition_normalize_round #(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sum_sign_in,
    input  logic [EXPO_WIDTH-1:0]   bigger_exponent_in,
    input  logic [MENT_WIDTH+4:0]   sum_mantissa_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   floating_addition_out,
    output logic                    overflow_out,
    output logic                    underflow_out
);

    // state | meaning
    // IDLE  | waiting for a raw sum
    // SHIFT | left-normalizing after cancellation, one bit per cycle
    // ROUND | round-to-nearest-even and pack
    // DONE  | result held until downstream takes it
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    localparam int MW = MENT_WIDTH + 5;
    localparam int HW = MW - 1;
    localparam int XW = EXPO_WIDTH + 2;
    localparam logic [XW-1:0] EXP_ONE = XW'(1);
    localparam logic [XW-1:0] EXP_MAX = XW'((2 ** EXPO_WIDTH) - 1);

    state_t                 state_q, state_d;
    logic                   alive_q;
    logic                   sign_q, sign_d;
    logic [XW-1:0]          exp_q, exp_d, exp_in_w;
    // carry bit is folded away at capture, so only {hidden, fraction, g, r, s} is kept
    logic [HW-1:0]          mant_q, mant_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d;

    logic                   round_up;
    logic [MENT_WIDTH+1:0]  sig_rnd;
    logic [XW-1:0]          exp_rnd;
    logic [MENT_WIDTH-1:0]  frac_rnd;
    logic                   hidden_rnd;

    assign in_ready              = alive_q && (state_q == IDLE);
    assign out_valid             = (state_q == DONE);
    assign floating_addition_out = result_q;
    assign overflow_out          = ovf_q;
    assign underflow_out         = unf_q;
    assign exp_in_w              = {2'b00, bigger_exponent_in};

    always_comb begin
        round_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        sig_rnd  = {1'b0, mant_q[HW-1:3]} + {{(MENT_WIDTH+1){1'b0}}, round_up};
        if (sig_rnd[MENT_WIDTH+1]) begin
            frac_rnd   = '0;
            hidden_rnd = 1'b1;
            exp_rnd    = exp_q + EXP_ONE;
        end else begin
            frac_rnd   = sig_rnd[MENT_WIDTH-1:0];
            hidden_rnd = sig_rnd[MENT_WIDTH];
            exp_rnd    = exp_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && alive_q) begin
                    sign_d = sum_sign_in;
                    exp_d  = exp_in_w;
                    mant_d = sum_mantissa_in[HW-1:0];
                    if (sum_mantissa_in == '0) begin
                        result_d = '0;
                        ovf_d    = 1'b0;
                        unf_d    = 1'b0;
                        state_d  = DONE;
                    end else if (sum_mantissa_in[MW-1]) begin
                        mant_d  = {sum_mantissa_in[MW-1:2], sum_mantissa_in[1] | sum_mantissa_in[0]};
                        exp_d   = exp_in_w + EXP_ONE;
                        state_d = ROUND;
                    end else if (sum_mantissa_in[MW-2] || exp_in_w <= EXP_ONE) begin
                        state_d = ROUND;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mant_d = {mant_q[HW-2:0], 1'b0};
                exp_d  = exp_q - EXP_ONE;
                if (mant_d[HW-1] || exp_d == EXP_ONE)
                    state_d = ROUND;
            end
            ROUND: begin
                if (exp_rnd >= EXP_MAX) begin
                    result_d = {sign_q, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                end else begin
                    result_d = {sign_q, hidden_rnd ? exp_rnd[EXPO_WIDTH-1:0] : {EXPO_WIDTH{1'b0}}, frac_rnd};
                    ovf_d    = 1'b0;
                    unf_d    = ~hidden_rnd;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            alive_q  <= 1'b0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            alive_q  <= 1'b1;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

endmodule
